// File: rtl/count_pkg.sv
// count_pkg: shared constants and elaboration helpers for the modulo up/down counter.
//   DIR_UP / DIR_DN      : values of the 'up' direction input
//   MODE_WRAP / MODE_SAT : values of the 'sat' mode input
//   clog2                : ceiling log2, used to size the prescaler
//   mod_legal/pre_legal  : parameter range checks used at elaboration
package count_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Legal modulus range is 2 .. 2**n.
  function automatic bit mod_legal(input int n, input int m);
    return (n >= 1) && (n <= 30) && (m >= 2) && (m <= (1 << n));
  endfunction

  function automatic bit pre_legal(input int p);
    return (p >= 1) && (p <= 256);
  endfunction

endpackage

// File: rtl/count_prescale.sv
// count_prescale: divides enabled cycles by PRE, emitting one tick per PRE enabled cycles.
//   clk     : clock, rising edge
//   clear   : synchronous active-high reset of the phase counter
//   en      : advance the phase counter by one
//   restart : zero the phase counter (takes priority over en, suppresses tick)
//   tick    : combinational, high on the enabled cycle that completes a period
// Only instantiated for PRE >= 2.
module count_prescale
  import count_pkg::*;
#(
  parameter int PRE = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = clog2(PRE);
  localparam logic [PW-1:0] LAST = PW'(PRE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = en && !restart && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/count_mod_updn.sv
// count_mod_updn: modulo-MOD up/down counter with load, prescaled enable,
// wrap/saturate mode, terminal-count pulse and sticky overflow flag.
//   clk, clear        : clock and synchronous active-high reset
//   en, up, sat       : count enable, direction (1=up), mode (1=saturate)
//   load, load_val    : synchronous load (clamped to MOD-1)
//   ovf_clr           : clears sticky ovf (a same-cycle overflow wins)
//   cap               : capture strobe (only with COUNT_CAPTURE_EN)
//   cnt_Q, tc, ovf    : registered count, terminal-count pulse, overflow flag
//   cap_Q             : captured count (constant 0 unless COUNT_CAPTURE_EN)
// Optional feature macro: COUNT_CAPTURE_EN.
module count_mod_updn
  import count_pkg::*;
#(
  parameter int N   = 4,
  parameter int MOD = 16,
  parameter int PRE = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         ovf_clr,
  input  logic         cap,
  output logic [N-1:0] cnt_Q,
  output logic         tc,
  output logic         ovf,
  output logic [N-1:0] cap_Q
);

  if (!mod_legal(N, MOD)) begin : g_bad_mod
    $error("count_mod_updn: MOD out of range 2..2**N");
  end
  if (!pre_legal(PRE)) begin : g_bad_pre
    $error("count_mod_updn: PRE out of range 1..256");
  end

  // N+1 bit domain so that MOD = 2**N is representable.
  localparam logic [N:0] MOD_W = (N+1)'(MOD);
  localparam logic [N:0] TOP_W = (N+1)'(MOD - 1);

  logic [N-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         tick;

  logic [N:0] cnt_ext;
  logic [N:0] load_ext;
  logic [N:0] nxt_ext;
  logic       at_end;

  if (PRE == 1) begin : g_no_pre
    assign tick = en;
  end else begin : g_pre
    count_prescale #(.PRE(PRE)) u_pre (
      .clk     (clk),
      .clear   (clear),
      .en      (en),
      .restart (load),
      .tick    (tick)
    );
  end

  assign cnt_ext  = {1'b0, cnt_q};
  assign load_ext = {1'b0, load_val};
  assign at_end   = (up == DIR_UP) ? (cnt_ext == TOP_W) : (cnt_ext == '0);

  always_comb begin
    nxt_ext = cnt_ext;
    if (up == DIR_UP) begin
      if (!at_end)               nxt_ext = cnt_ext + 1'b1;
      else if (sat == MODE_SAT)  nxt_ext = TOP_W;
      else                       nxt_ext = '0;
    end else begin
      if (!at_end)               nxt_ext = cnt_ext - 1'b1;
      else if (sat == MODE_SAT)  nxt_ext = '0;
      else                       nxt_ext = TOP_W;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q && !ovf_clr;
    if (load) begin
      cnt_d = (load_ext >= MOD_W) ? N'(TOP_W) : load_val;
    end else if (tick) begin
      cnt_d = N'(nxt_ext);
      if (at_end) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef COUNT_CAPTURE_EN
  logic [N-1:0] cap_q, cap_d;

  // Captures the count as it stood before this edge, so a coincident load is not seen.
  always_comb begin
    cap_d = cap ? cnt_q : cap_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign cap_Q = cap_q;
`else
  logic unused_cap;
  assign unused_cap = cap;
  assign cap_Q      = '0;
`endif

  assign cnt_Q = cnt_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_count_mod_updn.sv
// Directed bench for count_mod_updn: MOD=10 with PRE=1 (dut) and PRE=3 (dut_p).
module tb_count_mod_updn;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clear, en, up, sat, load, ovf_clr, cap;
  logic [N-1:0] load_val;
  logic [N-1:0] cnt_q, cap_q;
  logic         tc, ovf;

  logic         p_clear, p_en, p_up, p_sat, p_load, p_ovf_clr, p_cap;
  logic [N-1:0] p_load_val;
  logic [N-1:0] p_cnt_q, p_cap_q;
  logic         p_tc, p_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  count_mod_updn #(.N(N), .MOD(10), .PRE(1)) dut (
    .clk(clk), .clear(clear), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(load_val), .ovf_clr(ovf_clr), .cap(cap),
    .cnt_Q(cnt_q), .tc(tc), .ovf(ovf), .cap_Q(cap_q)
  );

  count_mod_updn #(.N(N), .MOD(10), .PRE(3)) dut_p (
    .clk(clk), .clear(p_clear), .en(p_en), .up(p_up), .sat(p_sat),
    .load(p_load), .load_val(p_load_val), .ovf_clr(p_ovf_clr), .cap(p_cap),
    .cnt_Q(p_cnt_q), .tc(p_tc), .ovf(p_ovf), .cap_Q(p_cap_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change after the falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk3(input string tag, input int c, input int t, input int o);
    chk({tag, ".cnt"}, 32'(cnt_q), 32'(c));
    chk({tag, ".tc"},  32'(tc),    32'(t));
    chk({tag, ".ovf"}, 32'(ovf),   32'(o));
  endtask

  int cap_exp;

  initial begin
    clear = 1; en = 0; up = 1; sat = 0; load = 0; ovf_clr = 0; cap = 0; load_val = '0;
    p_clear = 1; p_en = 0; p_up = 1; p_sat = 0; p_load = 0; p_ovf_clr = 0; p_cap = 0;
    p_load_val = '0;
    @(negedge clk);
    step();
    chk3("reset", 0, 0, 0);
    chk("reset.cap", 32'(cap_q), 0);

    // Up count with wrap: 1..9, 0, 1.
    clear = 0; en = 1; up = 1; sat = 0;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk3($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0);
    end

    // ovf_clr with no tick; en=0 freezes count.
    en = 0; ovf_clr = 1;
    step();
    chk3("ovfclr", 1, 0, 0);
    ovf_clr = 0;

    // Down with wrap from 1.
    load = 1; load_val = 4'd1;
    step();
    chk3("dn.load", 1, 0, 0);
    load = 0; up = 0; en = 1;
    step(); chk3("dn1", 0, 0, 0);
    step(); chk3("dn2", 9, 1, 1);
    step(); chk3("dn3", 8, 0, 1);

    // Saturate up from 8; clear ovf first.
    en = 0; ovf_clr = 1;
    step(); chk3("sat.clr", 8, 0, 0);
    ovf_clr = 0; en = 1; sat = 1; up = 1; load = 1; load_val = 4'd8;
    step(); chk3("sat.load", 8, 0, 0);
    load = 0;
    step(); chk3("sat1", 9, 0, 0);
    step(); chk3("sat2", 9, 1, 1);
    step(); chk3("sat3", 9, 1, 1);
    ovf_clr = 1;
    step(); chk3("sat4.setwins", 9, 1, 1);
    en = 0;
    step(); chk3("sat.idle", 9, 0, 0);
    ovf_clr = 0;

    // Saturate down at 0.
    load = 1; load_val = 4'd0; en = 1;
    step(); chk3("satdn.load", 0, 0, 0);
    load = 0; up = 0;
    step(); chk3("satdn1", 0, 1, 1);
    en = 0; ovf_clr = 1;
    step(); chk3("satdn.clr", 0, 0, 0);
    ovf_clr = 0;

    // Load clamp over a tick, then ovf survives a load, then clear beats load.
    en = 1; up = 1; sat = 0; load = 1; load_val = 4'd13;
    step(); chk3("clamp", 9, 0, 0);
    load = 0;
    step(); chk3("clamp.wrap", 0, 1, 1);
    load = 1; load_val = 4'd5;
    step(); chk3("load.keepovf", 5, 0, 1);
    clear = 1; load_val = 4'd3;
    step(); chk3("clear.load", 0, 0, 0);
    clear = 0; load = 0;

    // Capture.
    for (int i = 1; i <= 5; i++) step();
    chk("cap.pre", 32'(cnt_q), 5);
    cap = 1;
    step();
`ifdef COUNT_CAPTURE_EN
    cap_exp = 5;
`else
    cap_exp = 0;
`endif
    chk("cap.cnt6", 32'(cnt_q), 6);
    chk("cap.val", 32'(cap_q), 32'(cap_exp));
    cap = 0;
    step();
    chk("cap.cnt7", 32'(cnt_q), 7);
    chk("cap.hold", 32'(cap_q), 32'(cap_exp));
    cap = 1; load = 1; load_val = 4'd2;
    step();
`ifdef COUNT_CAPTURE_EN
    cap_exp = 7;
`endif
    chk("cap.load.cnt", 32'(cnt_q), 2);
    chk("cap.load.val", 32'(cap_q), 32'(cap_exp));
    cap = 0; load = 0; en = 0;

    // Prescaler PRE=3.
    p_clear = 0; p_en = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("pre%0d", k), 32'(p_cnt_q), 32'(k / 3));
    end
    step(); chk("pre.mid1", 32'(p_cnt_q), 3);
    p_en = 0;
    step(); chk("pre.off1", 32'(p_cnt_q), 3);
    step(); chk("pre.off2", 32'(p_cnt_q), 3);
    p_en = 1;
    step(); chk("pre.on1", 32'(p_cnt_q), 3);
    step(); chk("pre.on2", 32'(p_cnt_q), 4);
    // Load restarts the prescaler phase.
    step(); chk("pre.ph1", 32'(p_cnt_q), 4);
    p_load = 1; p_load_val = 4'd7;
    step(); chk("pre.load", 32'(p_cnt_q), 7);
    p_load = 0;
    step(); chk("pre.r1", 32'(p_cnt_q), 7);
    step(); chk("pre.r2", 32'(p_cnt_q), 7);
    step(); chk("pre.r3", 32'(p_cnt_q), 8);
    chk("pre.tc", 32'(p_tc), 0);
    chk("pre.ovf", 32'(p_ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
